ex_mul_sequencer: RTL and testbench

Multi-cycle multiply controller for the EX stage of the MIPS pipeline. The combinational ALU still executes every single-cycle operation. This block takes over `mul` (ALUControl 6'b011000) and computes it with an iterative shift-add over a fixed number of cycles. While it runs, it stalls the upstream pipeline, then presents the 32-bit product for one cycle so the EX result mux can steer it into EX/MEM.

---
 rtl/ex_mul_sequencer_if.sv | 31 +++
 rtl/ex_mul_sequencer.sv | 119 +++++++++++
 tb/tb_ex_mul_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mul_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mul_sequencer_if
// Description : EX-stage request/response bundle for the multi-cycle multiply
//               sequencer (pipeline side = master, sequencer side = slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [5:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Flush;
    logic             Stall;
    logic             Busy;
    logic [WIDTH-1:0] Result;
    logic             ResultValid;

    modport master (
        output Start, ALUControl, A, B, Flush,
        input  Stall, Busy, Result, ResultValid
    );

    modport slave (
        input  Start, ALUControl, A, B, Flush,
        output Stall, Busy, Result, ResultValid
    );
endinterface
`default_nettype wire

// File: rtl/ex_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ex_mul_sequencer
// Description : Iterative shift-add multiplier controller for the EX stage;
//               stalls the front end while running, pulses the product once.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mul_sequencer #(
    parameter int          WIDTH    = 32,
    parameter logic [5:0]  MUL_CODE = 6'b011000
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    ex_mul_sequencer_if.slave     bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;
    logic             r_busy;

    logic             w_is_mul;
    logic             w_accept;
    logic             w_finish;
    logic             w_stall;
    logic [WIDTH-1:0] w_acc_step;

    assign w_is_mul   = bus.Start && (bus.ALUControl == MUL_CODE);
    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_finish = 1'b0;
        w_stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mul) begin
                    w_accept = 1'b1;
                    w_stall  = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_stall = 1'b1;
                if (r_count == c_LAST) begin
                    w_finish = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                // ID/EX still holds the completed mul here, so Start is ignored.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // A squashed instruction must neither start nor retire a multiply.
        if (bus.Flush || Reset) begin
            w_next   = S_IDLE;
            w_accept = 1'b0;
            w_finish = 1'b0;
            w_stall  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= S_IDLE;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_acc          <= '0;
            r_count        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_busy         <= (w_next == S_RUN);
            r_result_valid <= (w_next == S_DONE);
            if (w_accept) begin
                r_mcand  <= bus.A;
                r_mplier <= bus.B;
                r_acc    <= '0;
                r_count  <= '0;
            end else if (r_state == S_RUN && !bus.Flush) begin
                r_acc    <= w_acc_step;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CW'(1);
            end
            if (w_finish) begin
                r_result <= w_acc_step;
            end
        end
    end

    assign bus.Stall       = w_stall;
    assign bus.Busy        = r_busy;
    assign bus.Result      = r_result;
    assign bus.ResultValid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_ex_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mul_sequencer
// Description : Scoreboard bench for ex_mul_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mul_sequencer;

    localparam int         c_WIDTH = 32;
    localparam logic [5:0] c_MUL   = 6'b011000;
    localparam logic [5:0] c_ADD   = 6'b100000;

    logic Clk;
    logic Reset;

    ex_mul_sequencer_if #(.WIDTH(c_WIDTH)) bus ();

    ex_mul_sequencer #(.WIDTH(c_WIDTH), .MUL_CODE(c_MUL)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_result = '0;

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Start      = 1'b0;
        bus.ALUControl = 6'd0;
        bus.A          = '0;
        bus.B          = '0;
        bus.Flush      = 1'b0;
    endtask

    // Issue one mul at the current cycle (cycle 0) and follow it to DONE.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input bit hold_start, input string name);
        int stalls;
        int busys;
        int rvc;
        logic [31:0] exp;
        stalls = 0; busys = 0; rvc = -1;
        bus.Start = 1'b1; bus.ALUControl = c_MUL; bus.A = a; bus.B = b;
        sb_q.push_back(a * b);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.Stall === 1'b1) stalls++;
            if (bus.Busy === 1'b1) busys++;
            if (bus.ResultValid === 1'b1) begin
                rvc = c;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_valid: Result=%h with empty scoreboard", name, bus.Result);
                end else begin
                    exp = sb_q.pop_front();
                    if (bus.Result !== exp) begin
                        errors++;
                        $display("FAIL %s result: got %h expected %h", name, bus.Result, exp);
                    end
                    last_result = exp;
                end
            end
            next_cycle();
            if (!hold_start) bus.Start = 1'b0;
            if (rvc >= 0) break;
        end
        checks++;
        if (rvc != 33) begin
            errors++;
            $display("FAIL %s valid_cycle: got %0d expected 33", name, rvc);
        end
        checks++;
        if (stalls != 33) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected 33", name, stalls);
        end
        checks++;
        if (busys != 32) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected 32", name, busys);
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        next_cycle();
        next_cycle();
        Reset = 1'b0;
        #1;
        checks++;
        if ({bus.Stall, bus.Busy, bus.ResultValid, bus.Result} !== '0) begin
            errors++;
            $display("FAIL reset_state: got stall=%b busy=%b rv=%b result=%h expected all 0",
                     bus.Stall, bus.Busy, bus.ResultValid, bus.Result);
        end
        next_cycle();
    endtask

    task automatic test_basic();
        run_mul(32'd7, 32'd6, 1'b0, "basic_7x6");
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_overflow();
        run_mul(32'hFFFF_FFFD, 32'd5, 1'b0, "neg3x5");
        idle_inputs(); next_cycle();
        run_mul(32'h8000_0000, 32'd2, 1'b0, "msb_x2");
        idle_inputs(); next_cycle();
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "neg1xneg1");
        idle_inputs(); next_cycle();
    endtask

    task automatic test_non_mul();
        int bad;
        bad = 0;
        bus.Start = 1'b1; bus.ALUControl = c_ADD; bus.A = 32'd3; bus.B = 32'd4;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus.Stall !== 1'b0 || bus.Busy !== 1'b0 || bus.ResultValid !== 1'b0) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL non_mul_quiet: got %0d active cycles expected 0", bad);
        end
        checks++;
        if (bus.Result !== last_result) begin
            errors++;
            $display("FAIL non_mul_result_hold: got %h expected %h", bus.Result, last_result);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_flush();
        int bad;
        // Flush together with a mul request: nothing is accepted.
        bus.Start = 1'b1; bus.ALUControl = c_MUL; bus.A = 32'd9; bus.B = 32'd9; bus.Flush = 1'b1;
        #1;
        checks++;
        if (bus.Stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_beats_start_stall: got %b expected 0", bus.Stall);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_beats_start_busy: got %b expected 0", bus.Busy);
        end
        next_cycle();
        // Mid-run flush at RUN cycle 10.
        bus.Start = 1'b1; bus.ALUControl = c_MUL; bus.A = 32'd11; bus.B = 32'd13;
        next_cycle();
        bus.Start = 1'b0;
        for (int c = 1; c < 10; c++) next_cycle();
        bus.Flush = 1'b1;
        #1;
        checks++;
        if (bus.Stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle_stall: got %b expected 0", bus.Stall);
        end
        next_cycle();
        bus.Flush = 1'b0;
        #1;
        checks++;
        if (bus.Stall !== 1'b0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_next_idle: got stall=%b busy=%b expected 0 0", bus.Stall, bus.Busy);
        end
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.ResultValid !== 1'b0) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0 || bus.Result !== last_result) begin
            errors++;
            $display("FAIL flush_no_result: got %0d pulses result=%h expected 0 pulses result=%h",
                     bad, bus.Result, last_result);
        end
        run_mul(32'd3, 32'd3, 1'b0, "after_flush_3x3");
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bus.Start = 1'b1; bus.ALUControl = c_MUL; bus.A = 32'd100; bus.B = 32'd7;
        next_cycle();
        bus.Start = 1'b0;
        for (int c = 0; c < 5; c++) next_cycle();
        Reset = 1'b1;
        bus.Start = 1'b1;
        next_cycle();
        Reset = 1'b0;
        bus.Start = 1'b0;
        #1;
        checks++;
        if ({bus.Stall, bus.Busy, bus.ResultValid, bus.Result} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got stall=%b busy=%b rv=%b result=%h expected all 0",
                     bus.Stall, bus.Busy, bus.ResultValid, bus.Result);
        end
        last_result = '0;
        next_cycle();
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: got busy=%b expected 0", bus.Busy);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        run_mul(32'd2, 32'd3, 1'b1, "b2b_first_2x3");
        run_mul(32'd4, 32'd5, 1'b1, "b2b_second_4x5");
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_overflow();
        test_non_mul();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
